// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host receiver front end:
//   - ps2_state_t : receive FSM states (IDLE, DATA, PARITY, STOP)
//   - ERR_*       : codes reported on rx_err_code alongside rx_err
//   - odd_parity_ok : true when data plus parity bit carry an odd number of ones
// ----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic [1:0] ERR_OVERFLOW = 2'd0;
   localparam logic [1:0] ERR_PARITY   = 2'd1;
   localparam logic [1:0] ERR_FRAMING  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   // PS/2 uses odd parity over the 8 data bits plus the parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ----------------------------------------------------------------------------
// ps2_clk_filter
// Synchronises the raw PS/2 clock pin, debounces it with a FILTER_LEN-deep
// shift register and flags each 1->0 transition of the filtered clock.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   clk_in   : raw PS/2 clock pin level
//   fall     : high for one cycle when the filtered clock falls
// ----------------------------------------------------------------------------
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clk_in,
   output logic fall
);

   logic                  sync1;
   logic                  sync2;
   logic [FILTER_LEN-1:0] shreg;
   logic                  filt;
   logic                  filt_prev;

   // Synchroniser, filter history and filtered-clock level. Idle bus is high,
   // so everything resets to ones to avoid a spurious fall after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         shreg     <= {FILTER_LEN{1'b1}};
         filt      <= 1'b1;
         filt_prev <= 1'b1;
      end else begin
         sync1 <= clk_in;
         sync2 <= sync1;
         shreg <= {shreg[FILTER_LEN-2:0], sync2};
         // Level only changes on a full run of identical samples; else hold.
         if (shreg == {FILTER_LEN{1'b0}}) begin
            filt <= 1'b0;
         end else if (shreg == {FILTER_LEN{1'b1}}) begin
            filt <= 1'b1;
         end else begin
            filt <= filt;
         end
         filt_prev <= filt;
      end
   end

   assign fall = filt_prev & ~filt;

endmodule

// File: rtl/ps2_rx_frontend.sv
// ----------------------------------------------------------------------------
// ps2_rx_frontend
// PS/2 host-side receiver: deserialises 11-bit device frames, checks start,
// parity and stop bits, holds each byte in a valid/ack register and holds the
// PS/2 clock low while a byte is unread or after an error.
// Ports:
//   clk, rst         : system clock, asynchronous active-high reset
//   ps2_clk_in       : raw PS/2 clock pin level
//   ps2_data_in      : raw PS/2 data pin level
//   ps2_clk_oe       : 1 = drive PS/2 clock low, 0 = release (high-Z)
//   rx_data/rx_valid : received byte and its held flag
//   rx_ack           : consumer takes the held byte
//   rx_err           : one-cycle error pulse, cause on rx_err_code
//   busy             : a frame is in progress
// ----------------------------------------------------------------------------
module ps2_rx_frontend
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int INHIBIT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       rx_err,
   output logic [1:0] rx_err_code,
   output logic       busy
);

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] INHIBIT_LOAD = 16'(INHIBIT_CYCLES);

   logic        fall;
   logic        data_s1;
   logic        data_s2;

   ps2_state_t  state,     state_nxt;
   logic [2:0]  bit_cnt,   bit_cnt_nxt;
   logic [7:0]  shift,     shift_nxt;
   logic        par_err,   par_err_nxt;
   logic [15:0] to_cnt,    to_cnt_nxt;
   logic [15:0] inhib_cnt, inhib_cnt_nxt;
   logic        valid_nxt;
   logic [7:0]  data_nxt;
   logic        err_nxt;
   logic [1:0]  code_nxt;
   logic        oe_nxt;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk    (clk),
      .rst    (rst),
      .clk_in (ps2_clk_in),
      .fall   (fall)
   );

   // Two-flop synchroniser for the data pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         data_s1 <= ps2_data_in;
         data_s2 <= data_s1;
      end
   end

   // Frame FSM, timeout, inhibit and handshake next-state logic.
   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      shift_nxt     = shift;
      par_err_nxt   = par_err;
      to_cnt_nxt    = to_cnt;
      inhib_cnt_nxt = (inhib_cnt != 16'd0) ? (inhib_cnt - 16'd1) : 16'd0;
      data_nxt      = rx_data;
      err_nxt       = 1'b0;
      code_nxt      = rx_err_code;

      // Ack is applied first so a byte completing this cycle can still load.
      if (rx_ack && rx_valid) begin
         valid_nxt = 1'b0;
      end else begin
         valid_nxt = rx_valid;
      end

      if (ps2_clk_oe) begin
         shift_nxt   = 8'h00;
         bit_cnt_nxt = 3'd0;
      end else begin
         shift_nxt   = shift;
      end

      if (inhib_cnt != 16'd0) begin
         // Clock is held low after an error: anything seen now is discarded.
         state_nxt   = IDLE;
         bit_cnt_nxt = 3'd0;
         shift_nxt   = 8'h00;
         to_cnt_nxt  = 16'd0;
      end else if (fall) begin
         to_cnt_nxt = 16'd0;
         case (state)
            IDLE: begin
               if (!data_s2) begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = 3'd0;
               end else begin
                  err_nxt  = 1'b1;
                  code_nxt = ERR_FRAMING;
               end
            end
            DATA: begin
               shift_nxt = {data_s2, shift[7:1]};
               if (bit_cnt == 3'd7) begin
                  state_nxt   = PARITY;
                  bit_cnt_nxt = 3'd0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end
            PARITY: begin
               par_err_nxt = ~odd_parity_ok(shift, data_s2);
               state_nxt   = STOP;
            end
            STOP: begin
               state_nxt   = IDLE;
               bit_cnt_nxt = 3'd0;
               if (!data_s2) begin
                  err_nxt  = 1'b1;
                  code_nxt = ERR_FRAMING;
               end else if (par_err) begin
                  err_nxt  = 1'b1;
                  code_nxt = ERR_PARITY;
               end else if (!valid_nxt) begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
               end else begin
                  err_nxt  = 1'b1;
                  code_nxt = ERR_OVERFLOW;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end else if (state != IDLE) begin
         if (to_cnt == TIMEOUT_LAST) begin
            err_nxt     = 1'b1;
            code_nxt    = ERR_TIMEOUT;
            state_nxt   = IDLE;
            bit_cnt_nxt = 3'd0;
            to_cnt_nxt  = 16'd0;
         end else begin
            to_cnt_nxt = to_cnt + 16'd1;
         end
      end else begin
         to_cnt_nxt = 16'd0;
      end

      if (err_nxt && (code_nxt != ERR_OVERFLOW)) begin
         inhib_cnt_nxt = INHIBIT_LOAD;
      end else begin
         inhib_cnt_nxt = inhib_cnt_nxt;
      end

      // Including the current rx_valid keeps the clock held one cycle past an ack.
      oe_nxt = (((valid_nxt | rx_valid) && (state_nxt == IDLE)) || (inhib_cnt_nxt != 16'd0));
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= 3'd0;
         shift       <= 8'h00;
         par_err     <= 1'b0;
         to_cnt      <= 16'd0;
         inhib_cnt   <= 16'd0;
         rx_data     <= 8'h00;
         rx_valid    <= 1'b0;
         rx_err      <= 1'b0;
         rx_err_code <= 2'd0;
         ps2_clk_oe  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         bit_cnt     <= bit_cnt_nxt;
         shift       <= shift_nxt;
         par_err     <= par_err_nxt;
         to_cnt      <= to_cnt_nxt;
         inhib_cnt   <= inhib_cnt_nxt;
         rx_data     <= data_nxt;
         rx_valid    <= valid_nxt;
         rx_err      <= err_nxt;
         rx_err_code <= code_nxt;
         ps2_clk_oe  <= oe_nxt;
         busy        <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// ----------------------------------------------------------------------------
// tb_ps2_rx_frontend
// Self-checking bench: directed scenarios followed by randomized frames whose
// outcome is predicted from the frame contents and the held-byte state.
// Timeout and inhibit lengths are shortened to keep the run short.
// ----------------------------------------------------------------------------
module tb_ps2_rx_frontend;

   localparam int FLEN = 8;
   localparam int TO   = 3000;
   localparam int INH  = 1500;
   localparam int HALF = 30;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       rx_err;
   logic [1:0] rx_err_code;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_fall = 0;
   int         last_err_cyc = 0;
   int         valid_rises = 0;
   int         oe_hi = 0;
   logic       prev_valid = 1'b0;
   logic [1:0] err_q[$];

   ps2_rx_frontend #(
      .FILTER_LEN     (FLEN),
      .TIMEOUT_CYCLES (TO),
      .INHIBIT_CYCLES (INH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ack      (rx_ack),
      .rx_err      (rx_err),
      .rx_err_code (rx_err_code),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock, then log what the outputs show in that cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (rx_err) begin
         err_q.push_back(rx_err_code);
         last_err_cyc = cyc;
      end
      if (rx_valid && !prev_valid) valid_rises++;
      prev_valid = rx_valid;
      if (ps2_clk_oe) oe_hi++;
   endtask

   task automatic clear_log();
      err_q.delete();
      valid_rises = 0;
      oe_hi = 0;
   endtask

   function automatic logic [1:0] first_code();
      return (err_q.size() > 0) ? err_q[0] : 2'bxx;
   endfunction

   // Device-side frame: data changes while the clock is high, device samples on fall.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                             input int nbits, input int glitch_bit, input bit ack_stop);
      logic [10:0] fr;
      fr = {stp, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         if (i == glitch_bit) begin
            repeat (10) tick();
            ps2_clk_in = 1'b0;
            repeat (5) tick();
            ps2_clk_in = 1'b1;
            repeat (10) tick();
         end
         ps2_data_in = fr[i];
         repeat (HALF) tick();
         ps2_clk_in = 1'b0;
         last_fall  = cyc;
         if (ack_stop && (i == 10)) begin
            // Completion edge is the one consuming the fall event (FLEN+3 after the pin).
            repeat (FLEN + 3) tick();
            rx_ack = 1'b1;
            tick();
            rx_ack = 1'b0;
            repeat (HALF - FLEN - 4) tick();
         end else begin
            repeat (HALF) tick();
         end
         ps2_clk_in = 1'b1;
      end
      ps2_data_in = 1'b1;
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      tick();
      rx_ack = 1'b0;
      tick();
   endtask

   task automatic wait_oe_low(input string tag);
      int n;
      n = 0;
      while (ps2_clk_oe && (n < INH + 500)) begin
         tick();
         n++;
      end
      check(tag, ps2_clk_oe, 1'b0);
   endtask

   initial begin
      logic [7:0] b;
      logic       p;
      logic       s;
      int         n;
      int         kind;
      logic       m_valid;
      logic [7:0] m_data;
      logic       m_err;
      logic [1:0] m_code;

      rst = 1'b1;
      ps2_clk_in = 1'b1;
      ps2_data_in = 1'b1;
      rx_ack = 1'b0;
      repeat (5) tick();
      rst = 1'b0;
      repeat (3) tick();

      check("rst_oe", ps2_clk_oe, 1'b0);
      check("rst_data", rx_data, 8'h00);
      check("rst_valid", rx_valid, 1'b0);
      check("rst_err", rx_err, 1'b0);
      check("rst_code", rx_err_code, 2'd0);
      check("rst_busy", busy, 1'b0);

      // Valid frame 0x1C (three ones, parity 0).
      clear_log();
      send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 1'b0);
      repeat (20) tick();
      check("ok_data", rx_data, 8'h1C);
      check("ok_valid", rx_valid, 1'b1);
      check("ok_rises", valid_rises, 1);
      check("ok_noerr", err_q.size(), 0);
      check("ok_oe_held", ps2_clk_oe, 1'b1);
      check("ok_idle", busy, 1'b0);
      rx_ack = 1'b1;
      tick();
      rx_ack = 1'b0;
      check("ack_valid_clr", rx_valid, 1'b0);
      check("ack_oe_lag", ps2_clk_oe, 1'b1);
      tick();
      check("ack_oe_rel", ps2_clk_oe, 1'b0);

      // Parity error: 0x1C with parity 1.
      clear_log();
      send_frame(8'h1C, 1'b1, 1'b1, 11, -1, 1'b0);
      repeat (INH + 50) tick();
      check("par_nerr", err_q.size(), 1);
      check("par_code", first_code(), 2'd1);
      check("par_valid", rx_valid, 1'b0);
      check("par_oe_len", oe_hi, INH);

      // Framing error, then a full frame inside the inhibit window.
      clear_log();
      b = 8'($urandom);
      send_frame(b, ~(^b), 1'b0, 11, -1, 1'b0);
      send_frame(8'h33, 1'b1, 1'b1, 11, -1, 1'b0);
      check("frm_nerr", err_q.size(), 1);
      check("frm_code", first_code(), 2'd2);
      check("frm_ignored", valid_rises, 0);
      check("frm_oe", ps2_clk_oe, 1'b1);
      wait_oe_low("frm_release");
      check("frm_after_valid", rx_valid, 1'b0);

      // Timeout: four clock pulses then silence.
      clear_log();
      send_frame(8'hA5, 1'b0, 1'b1, 4, -1, 1'b0);
      repeat (20) tick();
      check("to_busy", busy, 1'b1);
      n = 0;
      while ((err_q.size() == 0) && (n < TO + 200)) begin
         tick();
         n++;
      end
      check("to_nerr", err_q.size(), 1);
      check("to_code", first_code(), 2'd3);
      n = last_err_cyc - last_fall;
      check("to_delay_window", ((n >= TO + FLEN) && (n <= TO + FLEN + 8)), 1'b1);
      check("to_not_busy", busy, 1'b0);
      wait_oe_low("to_release");
      clear_log();
      send_frame(8'hF0, 1'b1, 1'b1, 11, -1, 1'b0);
      repeat (20) tick();
      check("to_next_data", rx_data, 8'hF0);
      check("to_next_valid", rx_valid, 1'b1);
      check("to_next_noerr", err_q.size(), 0);
      do_ack();

      // Glitch rejection: 5-cycle low pulse on the clock mid-frame.
      clear_log();
      send_frame(8'h5A, 1'b1, 1'b1, 11, 4, 1'b0);
      repeat (20) tick();
      check("gl_data", rx_data, 8'h5A);
      check("gl_valid", rx_valid, 1'b1);
      check("gl_noerr", err_q.size(), 0);
      do_ack();

      // Overflow: second frame completes while the first is unread.
      clear_log();
      send_frame(8'h21, 1'b1, 1'b1, 11, -1, 1'b0);
      repeat (20) tick();
      send_frame(8'h77, 1'b1, 1'b1, 11, -1, 1'b0);
      repeat (20) tick();
      check("ovf_nerr", err_q.size(), 1);
      check("ovf_code", first_code(), 2'd0);
      check("ovf_data_kept", rx_data, 8'h21);
      check("ovf_valid", rx_valid, 1'b1);

      // Ack coinciding with completion: new byte loads, no overflow.
      clear_log();
      send_frame(8'h3C, 1'b1, 1'b1, 11, -1, 1'b1);
      repeat (20) tick();
      check("ackc_noerr", err_q.size(), 0);
      check("ackc_data", rx_data, 8'h3C);
      check("ackc_valid", rx_valid, 1'b1);
      do_ack();

      // Randomized frames against the reference model.
      m_valid = 1'b0;
      m_data  = 8'h3C;
      for (int it = 0; it < 12; it++) begin
         b    = 8'($urandom);
         kind = int'($urandom_range(0, 3));
         p    = (kind == 2) ? ($countones(b) % 2 == 0) ? 1'b0 : 1'b1
                            : ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
         s    = (kind == 3) ? 1'b0 : 1'b1;
         m_err  = 1'b1;
         m_code = 2'd0;
         if (!s) begin
            m_code = 2'd2;
         end else if (($countones({b, p}) % 2) == 0) begin
            m_code = 2'd1;
         end else if (m_valid) begin
            m_code = 2'd0;
         end else begin
            m_err   = 1'b0;
            m_valid = 1'b1;
            m_data  = b;
         end
         clear_log();
         send_frame(b, p, s, 11, -1, 1'b0);
         repeat (20) tick();
         check("rnd_nerr", err_q.size(), m_err ? 1 : 0);
         if (m_err) check("rnd_code", first_code(), m_code);
         check("rnd_valid", rx_valid, m_valid);
         check("rnd_data", rx_data, m_data);
         if (m_err && (m_code != 2'd0)) repeat (INH) tick();
         if (m_valid && ($urandom_range(0, 1) == 1)) begin
            do_ack();
            m_valid = 1'b0;
            check("rnd_ack", rx_valid, 1'b0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_rx_frontend.md
# ps2_rx_frontend

PS/2 host-side receiver that sits directly upstream of the CPU's keyboard port. It filters the open-drain PS/2 clock, deserialises 11-bit device frames into bytes, and checks start, parity and stop bits. It presents each byte through a valid/ack holding register and drives the PS/2 clock low to hold off the device while a byte is unread or after an error. The top level converts `ps2_clk_oe` into the tri-state drive of the PS/2 clock pin.

## Interface
- `FILTER_LEN`, 8: consecutive identical samples needed before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 50000: maximum number of `clk` cycles allowed between falling edges inside a frame.
- `INHIBIT_CYCLES`, 5000: length of the clock-low hold after an error (100 µs at 50 MHz).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `ps2_clk_in` in 1: raw PS/2 clock pin level.
- `ps2_data_in` in 1: raw PS/2 data pin level.
- `ps2_clk_oe` out 1: 1 means drive the PS/2 clock pin low; 0 means release it (high-Z).
- `rx_data` out 8: received byte; stable while `rx_valid` is high.
- `rx_valid` out 1: a byte is held and unread.
- `rx_ack` in 1: consumer takes the byte; sampled on `clk`.
- `rx_err` out 1: one-cycle error pulse.
- `rx_err_code` out 2: error cause, valid whenever `rx_err` is high.
  - 0: overflow
  - 1: parity
  - 2: framing
  - 3: timeout
- `busy` out 1: a frame is in progress (state is not IDLE).

## Operation
- **Synchronisation:** both pins pass through 2-FF synchronisers.
- **Clock filter:** the synchronised clock feeds a `FILTER_LEN`-bit shift register.
  - The filtered clock goes to 0 when the register is all zeros and to 1 when it is all ones; otherwise it holds.
  - A fall event is the registered filtered clock going 1→0.
- **Data sampling:** the synchronised data line is sampled only on a fall event.
- **State machine:** IDLE → DATA → PARITY → STOP → IDLE.
  - **IDLE:** a fall event samples the start bit. Data 0 → DATA with `bit_cnt`=0. Data 1 → framing error, stay in IDLE.
  - **DATA:** each fall event shifts data in LSB first; after bit 7 → PARITY.
  - **PARITY:** the sampled bit must make the 9 bits (data + parity) odd; otherwise the parity error is latched and reported at STOP.
  - **STOP:** the sampled bit must be 1, else framing error. Framing takes precedence over parity.
  - **STOP, no error and `rx_valid`=0:** load `rx_data`, set `rx_valid`.
  - **STOP, no error and `rx_valid`=1:** drop the byte; raise overflow.
  - STOP always returns to IDLE.
- **Timeout:**
  - A 16-bit counter clears on every fall event and counts while the state is not IDLE.
  - Reaching `TIMEOUT_CYCLES` raises a timeout error and forces IDLE with `bit_cnt` cleared.
- **Handshake:**
  - `rx_ack` while `rx_valid`=1 clears `rx_valid` on the next edge.
  - `rx_ack` while `rx_valid`=0 is ignored.
  - If `rx_ack` coincides with a STOP completion, the ack is applied first and the new byte is loaded; `rx_valid` stays 1 and no overflow is raised.
- **Inhibit:** `ps2_clk_oe` = (`rx_valid` and state is IDLE) or (inhibit counter is nonzero).
  - Any parity, framing or timeout error loads the inhibit counter with `INHIBIT_CYCLES`, which then counts down to 0.
  - An error arriving while the counter is nonzero reloads it.
  - The shift register and `bit_cnt` are cleared while `ps2_clk_oe`=1, so a frame in progress during inhibit is discarded.

## Timing
- **Reset values:**
  - `ps2_clk_oe`=0, `rx_data`=0x00, `rx_valid`=0, `rx_err`=0, `rx_err_code`=0, `busy`=0.
  - State IDLE; filter register all ones; filtered clock 1; all counters 0.
- **Fall-event latency:** a fall event fires 2 + `FILTER_LEN` + 1 cycles after the pin's falling edge.
- **Output timing:**
  - All outputs are registered and change the cycle after the fall event that sampled the stop bit (or the cycle after the timeout count is reached).
  - `rx_err` is high for exactly one cycle per error.
  - `ps2_clk_oe` rises the same edge `rx_valid` rises.
  - After an ack, `ps2_clk_oe` falls on the cycle after `rx_valid` clears.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - the error-code constants ERR_OVERFLOW=0, ERR_PARITY=1, ERR_FRAMING=2, ERR_TIMEOUT=3.
- One sub-module, `ps2_clk_filter`, contains the synchroniser, the `FILTER_LEN` filter and the fall-event output. The data pin uses only its own 2-FF synchroniser in the parent.

## Test plan
- **Valid frame:** frame 0x1C with parity 0 at 12.5 kHz → `rx_data`=0x1C, one `rx_valid` rise, `ps2_clk_oe`=1 until ack, no `rx_err`.
- **Parity error:** frame 0x1C with parity 1 → `rx_err` pulse with code 1, `rx_valid` stays 0, `ps2_clk_oe` high for 5000 cycles.
- **Framing error:** stop bit driven 0 → code 2. A second frame starting during the inhibit window is ignored.
- **Timeout:** 4 clock pulses then silence → code 3 at 50000 cycles after the 4th fall event; the next full frame 0xF0 is received correctly.
- **Glitch rejection:** a 5-cycle low glitch on the PS/2 clock mid-frame produces no fall event; byte 0x5A is received intact.
- **Overflow and ack ordering:**
  - Second frame completing while `rx_valid`=1 (device ignoring inhibit) → code 0 and `rx_data` unchanged.
  - Ack on the completion cycle → new byte loaded and no error.
